// File: rtl/aux_reply_pkg.sv
// aux_reply_pkg: shared types and constants for the AUX reply parser.
//   ack_t   - decoded reply acknowledge code
//   state_t - burst-tracking FSM states
//   *_ACK_LSB - bit position of the 2-bit ack field in the header symbol
package aux_reply_pkg;

  typedef enum logic [1:0] {
    ACK   = 2'b00,
    NACK  = 2'b01,
    DEFER = 2'b10,
    RSVD  = 2'b11
  } ack_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HDR  = 2'b01,
    DATA = 2'b10
  } state_t;

  localparam int NATIVE_ACK_LSB = 4;
  localparam int I2C_ACK_LSB    = 6;

endpackage

// File: rtl/aux_reply_fifo.sv
// aux_reply_fifo: synchronous FIFO with wrap-bit pointers.
//   clk, rst      - clock, synchronous active-high reset (empties the FIFO)
//   wr_en/wr_data - write request; accepted when not full or when a pop
//                   happens in the same cycle
//   rd_en         - pop request; honoured only when not empty
//   rd_data       - head entry, 0 while empty
//   empty, full   - occupancy flags
module aux_reply_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_r;
  logic [AW:0]       rd_ptr_r;
  logic              empty_s;
  logic              full_s;
  logic              wr_ok_s;
  logic              rd_ok_s;

  // Same index with opposite wrap bits means the write pointer lapped the read pointer.
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign wr_ok_s = wr_en && (!full_s || rd_en);
  assign rd_ok_s = rd_en && !empty_s;

  // Pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Storage write; contents need no reset because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

  // Head output from stored state only, forced to 0 when empty.
  always_comb begin
    if (empty_s) begin
      rd_data = {DATA_W{1'b0}};
    end else begin
      rd_data = mem_r[rd_ptr_r[AW-1:0]];
    end
  end

  assign empty = empty_s;
  assign full  = full_s;

endmodule

// File: rtl/aux_reply_parser.sv
// aux_reply_parser: splits AUX reply bursts into a decoded ack header and a
// buffered data stream, with byte counting and length/reserved/overflow flags.
//   clk, rst             - clock, synchronous active-high reset
//   aux_in, aux_in_vld   - received symbols; vld high for a whole burst
//   aux_ctrl_i2c_native  - 1 = I2C-over-AUX header layout (sampled on header)
//   exp_len              - expected data byte count (sampled on header)
//   reply_ack(_vld)      - decoded ack, pulse when header decoded
//   reply_dec_i2c_native - mode of current/last reply
//   reply_data(_vld/_rdy)- FIFO head stream with consumer handshake
//   reply_done           - end-of-burst pulse with reply_byte_cnt, reply_len_err
//   reply_rsvd_err       - reserved ack code, with reply_ack_vld
//   reply_ovf            - sticky byte-drop flag, cleared by the next header
module aux_reply_parser
  import aux_reply_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] aux_in,
  input  logic              aux_in_vld,
  input  logic              aux_ctrl_i2c_native,
  input  logic [CNT_W-1:0]  exp_len,
  output logic [1:0]        reply_ack,
  output logic              reply_ack_vld,
  output logic              reply_dec_i2c_native,
  output logic [DATA_W-1:0] reply_data,
  output logic              reply_data_vld,
  input  logic              reply_data_rdy,
  output logic              reply_done,
  output logic [CNT_W-1:0]  reply_byte_cnt,
  output logic              reply_len_err,
  output logic              reply_rsvd_err,
  output logic              reply_ovf
);

  state_t             state_r;
  state_t             state_nxt_s;
  logic               hdr_s;
  logic               push_s;
  logic               done_s;
  ack_t               ack_s;

  ack_t               ack_r;
  logic               ack_vld_r;
  logic               i2c_r;
  logic [CNT_W-1:0]   exp_len_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               done_r;
  logic [CNT_W-1:0]   byte_cnt_r;
  logic               len_err_r;
  logic               rsvd_err_r;
  logic               ovf_r;

  logic               fifo_empty_s;
  logic               fifo_full_s;
  logic               pop_s;

  // Ack field position depends on the reply mode presented with the header.
  always_comb begin
    if (aux_ctrl_i2c_native) begin
      ack_s = ack_t'(aux_in[I2C_ACK_LSB +: 2]);
    end else begin
      ack_s = ack_t'(aux_in[NATIVE_ACK_LSB +: 2]);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state and per-cycle symbol classification.
  always_comb begin
    state_nxt_s = state_r;
    hdr_s       = 1'b0;
    push_s      = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (aux_in_vld) begin
          state_nxt_s = HDR;
          hdr_s       = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      HDR, DATA: begin
        if (aux_in_vld) begin
          state_nxt_s = DATA;
          push_s      = 1'b1;
        end else begin
          state_nxt_s = IDLE;
          done_s      = 1'b1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Head is popped whenever it is presented and the consumer is ready.
  assign pop_s = reply_data_rdy && !fifo_empty_s;

  // Header capture, byte counting and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_r      <= ACK;
      ack_vld_r  <= 1'b0;
      i2c_r      <= 1'b0;
      exp_len_r  <= {CNT_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      done_r     <= 1'b0;
      byte_cnt_r <= {CNT_W{1'b0}};
      len_err_r  <= 1'b0;
      rsvd_err_r <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      ack_vld_r  <= hdr_s;
      rsvd_err_r <= hdr_s && (ack_s == RSVD);
      if (hdr_s) begin
        ack_r     <= ack_s;
        i2c_r     <= aux_ctrl_i2c_native;
        exp_len_r <= exp_len;
        cnt_r     <= {CNT_W{1'b0}};
        ovf_r     <= 1'b0;
      end else begin
        // Counter saturates so a runaway burst cannot alias a short one.
        if (push_s && (cnt_r != {CNT_W{1'b1}})) begin
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        // A full FIFO implies non-empty, so the only rescue is a same-cycle pop.
        if (push_s && fifo_full_s && !pop_s) begin
          ovf_r <= 1'b1;
        end
      end
      done_r     <= done_s;
      byte_cnt_r <= done_s ? cnt_r : {CNT_W{1'b0}};
      len_err_r  <= done_s && (ack_r == ACK) && (cnt_r != exp_len_r);
    end
  end

  aux_reply_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_s),
    .wr_data (aux_in),
    .rd_en   (pop_s),
    .rd_data (reply_data),
    .empty   (fifo_empty_s),
    .full    (fifo_full_s)
  );

  assign reply_ack            = ack_r;
  assign reply_ack_vld        = ack_vld_r;
  assign reply_dec_i2c_native = i2c_r;
  assign reply_data_vld       = !fifo_empty_s;
  assign reply_done           = done_r;
  assign reply_byte_cnt       = byte_cnt_r;
  assign reply_len_err        = len_err_r;
  assign reply_rsvd_err       = rsvd_err_r;
  assign reply_ovf            = ovf_r;

endmodule

// File: tb/tb_aux_reply_parser.sv
// tb_aux_reply_parser: directed and randomized bursts checked every cycle
// against a queue-based reference model of the reply parser.
module tb_aux_reply_parser;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] aux_in;
  logic       aux_in_vld;
  logic       aux_ctrl_i2c_native;
  logic [4:0] exp_len;
  logic [1:0] reply_ack;
  logic       reply_ack_vld;
  logic       reply_dec_i2c_native;
  logic [7:0] reply_data;
  logic       reply_data_vld;
  logic       reply_data_rdy;
  logic       reply_done;
  logic [4:0] reply_byte_cnt;
  logic       reply_len_err;
  logic       reply_rsvd_err;
  logic       reply_ovf;

  aux_reply_parser #(.DATA_W(8), .FIFO_DEPTH(16), .CNT_W(5)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .aux_in               (aux_in),
    .aux_in_vld           (aux_in_vld),
    .aux_ctrl_i2c_native  (aux_ctrl_i2c_native),
    .exp_len              (exp_len),
    .reply_ack            (reply_ack),
    .reply_ack_vld        (reply_ack_vld),
    .reply_dec_i2c_native (reply_dec_i2c_native),
    .reply_data           (reply_data),
    .reply_data_vld       (reply_data_vld),
    .reply_data_rdy       (reply_data_rdy),
    .reply_done           (reply_done),
    .reply_byte_cnt       (reply_byte_cnt),
    .reply_len_err        (reply_len_err),
    .reply_rsvd_err       (reply_rsvd_err),
    .reply_ovf            (reply_ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [7:0] m_q[$];
  bit         m_in_burst;
  int         m_cnt;
  int         m_elen;
  logic [1:0] m_ack;
  bit         m_ack_vld;
  bit         m_mode;
  bit         m_done;
  int         m_cnt_out;
  bit         m_len_err;
  bit         m_rsvd;
  bit         m_ovf;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply the rules to the inputs present at the edge just taken.
  task automatic model_edge();
    bit pop;
    m_ack_vld = 1'b0;
    m_rsvd    = 1'b0;
    m_done    = 1'b0;
    m_len_err = 1'b0;
    m_cnt_out = 0;
    if (rst) begin
      m_q.delete();
      m_in_burst = 1'b0;
      m_cnt = 0; m_elen = 0; m_ack = 2'd0; m_mode = 1'b0; m_ovf = 1'b0;
    end else begin
      pop = reply_data_rdy && (m_q.size() > 0);
      if (pop) void'(m_q.pop_front());
      if (aux_in_vld && !m_in_burst) begin
        m_in_burst = 1'b1;
        m_ack      = aux_ctrl_i2c_native ? aux_in[7:6] : aux_in[5:4];
        m_ack_vld  = 1'b1;
        m_rsvd     = (m_ack == 2'd3);
        m_mode     = aux_ctrl_i2c_native;
        m_elen     = int'(exp_len);
        m_cnt      = 0;
        m_ovf      = 1'b0;
      end else if (aux_in_vld) begin
        if (m_cnt < 31) m_cnt++;
        if (m_q.size() < 16) m_q.push_back(aux_in);
        else m_ovf = 1'b1;
      end else if (m_in_burst) begin
        m_in_burst = 1'b0;
        m_done     = 1'b1;
        m_cnt_out  = m_cnt;
        m_len_err  = (m_ack == 2'd0) && (m_cnt != m_elen);
      end
    end
  endtask

  task automatic compare_outputs();
    check_eq("ack_vld", reply_ack_vld, m_ack_vld);
    check_eq("ack", reply_ack, m_ack);
    check_eq("rsvd_err", reply_rsvd_err, m_rsvd);
    check_eq("mode", reply_dec_i2c_native, m_mode);
    check_eq("data_vld", reply_data_vld, m_q.size() > 0);
    check_eq("data", reply_data, (m_q.size() > 0) ? m_q[0] : 8'h00);
    check_eq("done", reply_done, m_done);
    check_eq("len_err", reply_len_err, m_len_err);
    check_eq("ovf", reply_ovf, m_ovf);
    if (m_done) check_eq("byte_cnt", reply_byte_cnt, m_cnt_out);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_outputs();
  endtask

  // rdy_mode: 0 = stalled, 1 = always ready, 2 = random
  task automatic set_rdy(input int rdy_mode);
    case (rdy_mode)
      0: reply_data_rdy = 1'b0;
      1: reply_data_rdy = 1'b1;
      default: reply_data_rdy = 1'($urandom_range(0, 1));
    endcase
  endtask

  // One burst: header, n data bytes (base+i, or random if base<0), then gap idle cycles.
  task automatic burst(input logic [7:0] hdr, input bit i2c, input logic [4:0] elen,
                       input int n, input int base, input int rdy_mode, input int gap);
    aux_in_vld = 1'b1; aux_in = hdr; aux_ctrl_i2c_native = i2c; exp_len = elen;
    set_rdy(rdy_mode);
    step();
    for (int i = 0; i < n; i++) begin
      aux_ctrl_i2c_native = 1'($urandom_range(0, 1));
      exp_len = 5'($urandom_range(0, 31));
      aux_in = (base < 0) ? 8'($urandom_range(0, 255)) : 8'(base + i);
      set_rdy(rdy_mode);
      step();
    end
    for (int g = 0; g < gap; g++) begin
      aux_in_vld = 1'b0;
      aux_in = 8'($urandom_range(0, 255));
      set_rdy(rdy_mode);
      step();
    end
  endtask

  initial begin
    rst = 1'b1; aux_in = 8'h00; aux_in_vld = 1'b0; aux_ctrl_i2c_native = 1'b0;
    exp_len = 5'd0; reply_data_rdy = 1'b0;
    step(); step();
    rst = 1'b0;
    step();

    // Native ACK, 4 bytes in order, length matches.
    burst(8'h00, 1'b0, 5'd4, 4, 'hA0, 1, 2);
    // I2C NACK, no data.
    burst(8'h40, 1'b1, 5'd0, 0, 0, 1, 2);
    // Short ACK: length error.
    burst(8'h00, 1'b0, 5'd4, 2, 'h10, 1, 2);
    // Overflow: consumer stalled, 18 bytes into 16 entries.
    burst(8'h00, 1'b0, 5'd18, 18, 'h20, 0, 2);
    // Reserved code; its header clears ovf, drain meanwhile.
    burst(8'h30, 1'b0, 5'd3, 3, 'h50, 1, 20);
    // Back-to-back bursts with a one-cycle gap, stalled consumer with full-FIFO push+pop.
    burst(8'h10, 1'b0, 5'd1, 1, 'h60, 1, 1);
    burst(8'h80, 1'b1, 5'd0, 17, 'h70, 0, 0);
    aux_in_vld = 1'b1; aux_in = 8'hEE; reply_data_rdy = 1'b1;
    step(); step();
    aux_in_vld = 1'b0;
    step(); step();

    // Reset at byte 3 with vld still high; next high cycle is a new header.
    burst(8'h00, 1'b0, 5'd5, 3, 'h90, 0, 0);
    rst = 1'b1; aux_in_vld = 1'b1; aux_in = 8'h93;
    step();
    rst = 1'b0;
    burst(8'h00, 1'b0, 5'd2, 2, 'hC0, 1, 2);

    // Saturating counter: 35 data bytes.
    burst(8'h00, 1'b0, 5'd31, 35, -1, 2, 3);

    // Randomized bursts.
    for (int k = 0; k < 60; k++) begin
      burst(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 20)), $urandom_range(0, 22), -1,
            $urandom_range(0, 2), $urandom_range(1, 4));
    end

    aux_in_vld = 1'b0;
    for (int d = 0; d < 20; d++) begin
      reply_data_rdy = 1'b1;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aux_reply_parser.md
# aux_reply_parser

Parametrised successor to the AUX reply decoder, sitting between the AUX receive deserialiser and the transaction controller. It splits each reply burst into a decoded command/ack header and a buffered data stream, counts data bytes, and checks the count against the expected length. Supports native and I2C-over-AUX replies. It adds back-pressure via an internal FIFO and reports length, reserved-code and overflow errors.

## Interface
- `DATA_W`, 8: symbol width of `aux_in` and `reply_data`.
- `FIFO_DEPTH`, 16: data FIFO entries; power of two, ≥2.
- `CNT_W`, 5: byte-counter width; must hold `FIFO_DEPTH`+1 without wrap.

- `clk`  in  1: clock.
- `rst`  in  1: synchronous, active-high reset.
- `aux_in`  in  DATA_W: received symbol.
- `aux_in_vld`  in  1: high for every symbol of one reply burst; low between bursts.
- `aux_ctrl_i2c_native`  in  1: 1 = I2C-over-AUX, 0 = native; sampled on the header symbol.
- `exp_len`  in  CNT_W: expected data bytes; sampled on the header symbol.
- `reply_ack`  out  2: decoded ack code.
- `reply_ack_vld`  out  1: one-cycle pulse when the header is decoded.
- `reply_dec_i2c_native`  out  1: mode of the current/last reply, held until the next header.
- `reply_data`  out  DATA_W: FIFO head.
- `reply_data_vld`  out  1: FIFO non-empty.
- `reply_data_rdy`  in  1: consumer pop; a pop occurs when `vld && rdy`.
- `reply_done`  out  1: one-cycle pulse at end of burst.
- `reply_byte_cnt`  out  CNT_W: data bytes received in the burst; valid with `reply_done`.
- `reply_len_err`  out  1: with `reply_done`; the ack is ACK and `reply_byte_cnt != exp_len`.
- `reply_rsvd_err`  out  1: with `reply_ack_vld`; the ack code is reserved (2'b11).
- `reply_ovf`  out  1: sticky; a byte was dropped on a full FIFO. Cleared on the next header.

## Operation
- FSM `IDLE`, `HDR`, `DATA`:
  - `IDLE`→`HDR` on `aux_in_vld`. This symbol is the header.
  - `HDR`→`DATA` next cycle if `aux_in_vld` is still high.
  - `HDR`/`DATA`→`IDLE` when `aux_in_vld` falls. `reply_done` is issued on that transition.
- Header decode:
  - Native: `reply_ack = aux_in[5:4]`.
  - I2C: `reply_ack = aux_in[7:6]`.
  - Codes: 00 ACK, 01 NACK, 10 DEFER, 11 reserved.
- Data handling:
  - Every non-header symbol while `aux_in_vld` is high is pushed into the FIFO and increments the byte counter.
  - The counter saturates at all-ones.
- Full FIFO:
  - A push when full and no same-cycle pop drops the byte and sets `reply_ovf`. The byte is still counted.
  - A push when full with a same-cycle pop succeeds.
- FIFO contents persist across bursts. The consumer drains at its own pace.
- The length check applies only to ACK replies.
  - NACK/DEFER/reserved replies force `reply_len_err = 0`.
  - Their data bytes are still buffered.
- Back-to-back bursts: `aux_in_vld` low for one cycle is sufficient. `IDLE` accepts a new header on the next high cycle.
- Reset mid-burst: all state clears and the FIFO empties. A still-high `aux_in_vld` after reset release is treated as a new header.

## Timing
- Reset values:
  - All outputs are 0 and the FIFO is empty.
  - `reply_data` is 0 when empty.
  - FSM is in `IDLE`; counter is 0.
- Ack: header sampled at edge N → `reply_ack`/`reply_ack_vld`/`reply_rsvd_err` are valid after edge N. `reply_ack` holds until the next header.
- Data latency:
  - A byte pushed at edge N into an empty FIFO shows `reply_data_vld` after edge N.
  - The FIFO output is registered; there is no fall-through within the same cycle.
- Done: `aux_in_vld` is low at edge M → `reply_done`, `reply_byte_cnt`, `reply_len_err` are valid after edge M, for one cycle.
- Simultaneous push and pop: occupancy is unchanged, and ordering is preserved.

## Structure
- Package `aux_reply_pkg`:
  - `ack_t` enum: ACK, NACK, DEFER, RSVD.
  - `state_t` enum: IDLE, HDR, DATA.
  - Ack bit-field position constants for native and I2C.
- Sub-module `aux_reply_fifo`: synchronous FIFO, parameters `DATA_W`/`FIFO_DEPTH`, pointers with an extra wrap bit, full/empty flags.

## Test plan
- Native ACK: header 8'h00 then 4 data bytes A0..A3, `exp_len`=4, rdy=1 → `reply_ack`=00 pulse; A0..A3 out in order; done with cnt=4, `len_err`=0.
- I2C NACK: header 8'h40, `aux_ctrl_i2c_native`=1, then no data → `reply_ack`=01; done with cnt=0, `len_err`=0.
- Short ACK: native header 8'h00, 2 bytes, `exp_len`=4 → done with cnt=2, `len_err`=1.
- Overflow: rdy=0, header + 18 bytes, DEPTH 16 → 16 bytes buffered; `reply_ovf`=1; cnt=18. The next header clears `ovf`.
- Reserved code: native header 8'h30 → `reply_ack`=11, `reply_rsvd_err`=1.
- Reset at byte 3 of a burst → all outputs 0 and FIFO empty the next cycle. A subsequent burst decodes normally.
